clk_div_prog: RTL and testbench



---
 rtl/clk_div_prog.sv | 168 ++++++++++++++++
 tb/tb_clk_div_prog.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider (ratio 2..2^WIDTH-1)
// with a glitch-free, break-before-make bypass path.
// Ratio changes are deferred to a period boundary so clko never emits a runt.
// Optional build macro CLK_DIV_ODD50_EN: adds a negedge flop that stretches
// the high phase by half a clki period for odd ratios (exact 50% duty).
// Handshake: div_ld is a one-cycle strobe with no back-pressure. The loaded
// value is held in div_pend until the next period boundary. div_ack then
// pulses for one cycle, in the same cycle that div_cur shows the new ratio.
module clk_div_prog #(
   parameter int WIDTH     = 8,
   parameter int RESET_DIV = 2
) (
   input  logic             clki,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] div,
   input  logic             div_ld,
   input  logic             div_en,
   output logic             clko,
   output logic [WIDTH-1:0] div_cur,
   output logic             div_pend,
   output logic             div_ack
);

   // Output-mode sequencer: the two BRK states keep both enables low.
   typedef enum logic [1:0] {
      ST_BRK_A = 2'd0,
      ST_BRK_B = 2'd1,
      ST_DIV   = 2'd2,
      ST_BYP   = 2'd3
   } mode_e;

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   mode_e            mode_q, mode_d;
   logic             dv_en_q, dv_en_d;
   logic             byp_req_q, byp_req_d;
   logic             byp_en_q, byp_en_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] pend_val_q, pend_val_d;
   logic             div_pend_q, div_pend_d;
   logic             div_ack_q, div_ack_d;
   logic             clk_q, clk_d;
   logic [WIDTH-1:0] div_clamp;
   logic             wrap;
   logic             apply;
   logic             clk_div;

   // Mode sequencing: leave divided mode only while clk_q is low, and
   // always pass through two break cycles before the other path is enabled.
   always_comb begin
      mode_d    = mode_q;
      dv_en_d   = dv_en_q;
      byp_req_d = byp_req_q;
      case (mode_q)
         ST_BYP: begin
            if (div_en) begin
               byp_req_d = 1'b0;
               mode_d    = ST_BRK_A;
            end
         end
         ST_BRK_A: mode_d = ST_BRK_B;
         ST_BRK_B: begin
            if (div_en) begin
               dv_en_d = 1'b1;
               mode_d  = ST_DIV;
            end else begin
               byp_req_d = 1'b1;
               mode_d    = ST_BYP;
            end
         end
         ST_DIV: begin
            if (!div_en && !clk_q) begin
               dv_en_d = 1'b0;
               mode_d  = ST_BRK_A;
            end
         end
         default: mode_d = ST_BRK_A;
      endcase
   end

   // Ratio capture and deferred application at the period boundary.
   always_comb begin
      div_clamp  = (div < MIN_DIV) ? MIN_DIV : div;
      wrap       = dv_en_q && (cnt_q == (div_cur_q - ONE));
      apply      = div_pend_q && (wrap || !dv_en_q);
      div_cur_d  = apply ? pend_val_q : div_cur_q;
      pend_val_d = div_ld ? div_clamp : pend_val_q;
      div_pend_d = div_ld || (div_pend_q && !apply);
      div_ack_d  = apply;
   end

   // Period counter and registered divided clock; idle (0) when not dividing.
   always_comb begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (!dv_en_d) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (!dv_en_q || wrap) begin
         // New period: cnt restarts at 0, which is always in the high half.
         cnt_d = '0;
         clk_d = 1'b1;
      end else begin
         cnt_d = cnt_q + ONE;
         clk_d = (cnt_d < (div_cur_q >> 1));
      end
   end

   // All rising-edge state.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= ST_BRK_A;
         dv_en_q    <= 1'b0;
         byp_req_q  <= 1'b0;
         cnt_q      <= '0;
         clk_q      <= 1'b0;
         div_cur_q  <= RST_DIV;
         pend_val_q <= RST_DIV;
         div_pend_q <= 1'b0;
         div_ack_q  <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         dv_en_q    <= dv_en_d;
         byp_req_q  <= byp_req_d;
         cnt_q      <= cnt_d;
         clk_q      <= clk_d;
         div_cur_q  <= div_cur_d;
         pend_val_q <= pend_val_d;
         div_pend_q <= div_pend_d;
         div_ack_q  <= div_ack_d;
      end
   end

   // Bypass enable changes only while clki is low.
   always_comb byp_en_d = byp_req_q;

   // Falling-edge bypass-enable flop.
   always_ff @(negedge clki or negedge rst_n) begin
      if (!rst_n) byp_en_q <= 1'b0;
      else        byp_en_q <= byp_en_d;
   end

`ifdef CLK_DIV_ODD50_EN
   logic clk_n_q, clk_n_d;

   // Half-period stretch of the high phase, odd ratios only.
   always_comb clk_n_d = clk_q & div_cur_q[0];

   // Falling-edge stretch flop.
   always_ff @(negedge clki or negedge rst_n) begin
      if (!rst_n) clk_n_q <= 1'b0;
      else        clk_n_q <= clk_n_d;
   end

   assign clk_div = clk_q | clk_n_q;
`else
   assign clk_div = clk_q;
`endif

   assign clko     = (clki & byp_en_q) | (clk_div & dv_en_q);
   assign div_cur  = div_cur_q;
   assign div_pend = div_pend_q;
   assign div_ack  = div_ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: self-checking bench for clk_div_prog.
// clko is sampled 2 time units after every clki edge, so waveform widths are
// measured in half clki periods against a reference built from the ratio rules.
module tb_clk_div_prog;

   localparam int W       = 8;
   localparam int RST_DIV = 2;
   localparam int LIMIT   = 1200;

   logic         clki = 1'b0;
   logic         rst_n;
   logic [W-1:0] div;
   logic         div_ld;
   logic         div_en;
   logic         clko;
   logic [W-1:0] div_cur;
   logic         div_pend;
   logic         div_ack;

   int           n_tests     = 0;
   int           n_fail      = 0;
   int           runt_cnt    = 0;
   int           overlap_cnt = 0;
   int unsigned  model_n;
   realtime      last_edge_t = 0;

   clk_div_prog #(.WIDTH(W), .RESET_DIV(RST_DIV)) dut (
      .clki     (clki),
      .rst_n    (rst_n),
      .div      (div),
      .div_ld   (div_ld),
      .div_en   (div_en),
      .clko     (clko),
      .div_cur  (div_cur),
      .div_pend (div_pend),
      .div_ack  (div_ack)
   );

   // clock
   always #5 clki = ~clki;

   // any clko pulse shorter than half a clki period outside reset is a runt
   always @(clko) begin
      if (rst_n && (($realtime - last_edge_t) < 4.5)) runt_cnt++;
      last_edge_t = $realtime;
   end

   // break-before-make watch on the two output enables
   always @(dut.byp_en_q or dut.dv_en_q) begin
      if (dut.byp_en_q && dut.dv_en_q) overlap_cnt++;
   end

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference waveform: high / low widths in half clki periods for ratio n
   function automatic int unsigned exp_hi(input int unsigned n);
`ifdef CLK_DIV_ODD50_EN
      return n;
`else
      return 2 * (n / 2);
`endif
   endfunction

   function automatic int unsigned exp_lo(input int unsigned n);
      return 2 * n - exp_hi(n);
   endfunction

   task automatic tick();
      @(posedge clki);
      #2;
   endtask

   task automatic half();
      @(clki);
      #2;
   endtask

   task automatic wait_rise(output bit ok);
      logic prev;
      ok   = 1'b0;
      prev = clko;
      for (int i = 0; i < LIMIT; i++) begin
         half();
         if (!prev && clko) begin
            ok = 1'b1;
            break;
         end
         prev = clko;
      end
   endtask

   // called on the first high sample; counts the high run then the low run
   task automatic measure(output int unsigned hi, output int unsigned lo, output bit ok);
      hi = 1;
      lo = 0;
      ok = 1'b0;
      while (hi < LIMIT) begin
         half();
         if (!clko) break;
         hi++;
      end
      if (!clko) begin
         lo = 1;
         while (lo < LIMIT) begin
            half();
            if (clko) begin
               ok = 1'b1;
               break;
            end
            lo++;
         end
      end
   endtask

   task automatic check_period(input string tag);
      int unsigned hi, lo;
      bit ok;
      wait_rise(ok);
      check_eq({tag, "_rise"}, ok, 1);
      measure(hi, lo, ok);
      check_eq({tag, "_done"}, ok, 1);
      check_eq({tag, "_hi"}, hi, exp_hi(model_n));
      check_eq({tag, "_lo"}, lo, exp_lo(model_n));
   endtask

   task automatic load_and_check(input int unsigned n_req);
      int unsigned n_exp;
      bit ok;
      n_exp  = (n_req < 2) ? 2 : n_req;
      div    = W'(n_req);
      div_ld = 1'b1;
      tick();
      div_ld = 1'b0;
      check_eq("ld_pend", div_pend, 1);
      ok = 1'b0;
      for (int c = 0; c < int'(model_n) + 4; c++) begin
         if (div_ack) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_eq("ld_ack_seen", ok, 1);
      check_eq("ld_cur", div_cur, n_exp);
      check_eq("ld_pend_clr", div_pend, 0);
      tick();
      check_eq("ld_ack_1cyc", div_ack, 0);
      model_n = n_exp;
      check_period("ld_per");
   endtask

   initial begin
      int unsigned hi, lo, acks, match, n;
      bit ok;
      rst_n   = 1'b0;
      div     = '0;
      div_ld  = 1'b0;
      div_en  = 1'b1;
      model_n = RST_DIV;

      // reset values
      #23;
      check_eq("rst_clko", clko, 0);
      check_eq("rst_cur", div_cur, RST_DIV);
      check_eq("rst_pend", div_pend, 0);
      check_eq("rst_ack", div_ack, 0);
      tick();
      rst_n = 1'b1;
      check_period("rst_f2");

      // directed ratios: odd, clamp, maximum
      repeat ($urandom_range(0, 1)) tick();
      load_and_check(5);
      load_and_check(0);
      load_and_check(1);
      load_and_check(255);

      // two loads before one wrap: only the last applies, one ack
      div    = W'(6);
      div_ld = 1'b1;
      tick();
      div    = W'(10);
      tick();
      div_ld = 1'b0;
      check_eq("dbl_pend", div_pend, 1);
      acks = 0;
      for (int c = 0; c < 300; c++) begin
         if (div_ack) acks++;
         tick();
      end
      check_eq("dbl_acks", acks, 1);
      check_eq("dbl_cur", div_cur, 10);
      model_n = 10;
      check_period("dbl_per");

      // leave divided mode in the middle of a high phase at N=8
      load_and_check(8);
      wait_rise(ok);
      check_eq("exit_rise", ok, 1);
      div_en = 1'b0;
      measure(hi, lo, ok);
      check_eq("exit_done", ok, 1);
      check_eq("exit_hi", hi, 8);
      check_eq("exit_gap_min", (lo >= 2), 1);
      check_eq("exit_gap_max", (lo <= 16), 1);
      match = 0;
      for (int i = 0; i < 8; i++) begin
         half();
         if (clko === clki) match++;
      end
      check_eq("byp_follow", match, 8);
      check_eq("byp_cur", div_cur, 8);

      // load in bypass applies on the next edge
      div    = W'(7);
      div_ld = 1'b1;
      tick();
      div_ld = 1'b0;
      check_eq("byp_ld_pend", div_pend, 1);
      check_eq("byp_ld_noack", div_ack, 0);
      tick();
      check_eq("byp_ld_cur", div_cur, 7);
      check_eq("byp_ld_ack", div_ack, 1);
      check_eq("byp_ld_pclr", div_pend, 0);
      tick();
      check_eq("byp_ld_ack1", div_ack, 0);
      model_n = 7;

      // re-enter divided mode
      div_en = 1'b1;
      tick();
      tick();
      check_eq("entry_gap", clko, 0);
      wait_rise(ok);
      check_eq("entry_rise", ok, 1);
      measure(hi, lo, ok);
      check_eq("entry_hi", hi, exp_hi(7));
      check_eq("entry_lo", lo, exp_lo(7));

      // randomized ratios at random points in the period
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(0, 40);
         repeat ($urandom_range(0, model_n)) tick();
         load_and_check(n);
      end

      // div_en glitched low for one cycle mid-period, then recovery
      repeat ($urandom_range(0, model_n)) tick();
      div_en = 1'b0;
      tick();
      div_en = 1'b1;
      repeat (2 * model_n + 8) tick();
      check_period("toggle_per");

      // asynchronous reset in the middle of a high phase at N=6
      load_and_check(6);
      tick();
      check_eq("prerst_high", clko, 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_clko", clko, 0);
      check_eq("rst_mid_cur", div_cur, RST_DIV);
      check_eq("rst_mid_pend", div_pend, 0);
      tick();
      tick();
      rst_n   = 1'b1;
      model_n = RST_DIV;
      check_period("rst_mid_per");

      check_eq("no_overlap", overlap_cnt, 0);
      check_eq("no_runt", runt_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
